clock_div_multi: RTL and testbench

//  - Multi-channel programmable clock divider: NUM_CH independent toggle outputs from i_clk.
//  - Each channel also has a single-cycle tick output.
//  - Half-period is runtime-writable per channel. New values take effect glitch-free at the next

---
 rtl/clock_div_multi.sv | 103 ++++++++++
 tb/tb_clock_div_multi.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider with per-channel toggle clock and rising-edge tick.
// Optional CLKDIV_SYNC_EN adds i_sync to phase-align all channels and apply pending half-periods.
module clock_div_multi #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 24,
  parameter int DEFAULT_HALF = 625_000,
  localparam int SEL_W       = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_wr_en,
  input  logic [SEL_W-1:0]  i_wr_sel,
  input  logic [CNT_W-1:0]  i_wr_half,
`ifdef CLKDIV_SYNC_EN
  input  logic              i_sync,
`endif
  output logic [NUM_CH-1:0] o_clk,
  output logic [NUM_CH-1:0] o_tick,
  output logic              o_wr_err
);

  localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] cnt_r      [NUM_CH];
  logic [CNT_W-1:0] half_r     [NUM_CH];
  logic [CNT_W-1:0] pend_r     [NUM_CH];
  logic             pend_vld_r [NUM_CH];
  logic             wr_ok_s;
  logic             wr_bad_s;
  logic             sync_s;

  // Write qualification: a zero half-period or out-of-range channel is rejected.
  always_comb begin
    wr_ok_s  = i_wr_en && (int'(i_wr_sel) < NUM_CH) && (i_wr_half != ZERO);
    wr_bad_s = i_wr_en && !wr_ok_s;
`ifdef CLKDIV_SYNC_EN
    sync_s   = i_sync;
`else
    sync_s   = 1'b0;
`endif
  end

  // Per-channel counters; a write landing on a terminal edge stays pending for the next one.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_r[c]      <= ZERO;
        half_r[c]     <= DEF_HALF;
        pend_r[c]     <= DEF_HALF;
        pend_vld_r[c] <= 1'b0;
      end
      o_clk  <= {NUM_CH{1'b0}};
      o_tick <= {NUM_CH{1'b0}};
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (sync_s) begin
          cnt_r[c]  <= ZERO;
          o_clk[c]  <= 1'b0;
          o_tick[c] <= 1'b0;
          if (pend_vld_r[c]) begin
            half_r[c]     <= pend_r[c];
            pend_vld_r[c] <= 1'b0;
          end
        end else if (!i_en[c]) begin
          o_tick[c] <= 1'b0;
          if (pend_vld_r[c]) begin
            half_r[c]     <= pend_r[c];
            cnt_r[c]      <= ZERO;
            pend_vld_r[c] <= 1'b0;
          end
        end else if (cnt_r[c] == half_r[c] - ONE) begin
          cnt_r[c]  <= ZERO;
          o_clk[c]  <= ~o_clk[c];
          o_tick[c] <= ~o_clk[c];
          if (pend_vld_r[c]) begin
            half_r[c]     <= pend_r[c];
            pend_vld_r[c] <= 1'b0;
          end
        end else begin
          cnt_r[c]  <= cnt_r[c] + ONE;
          o_tick[c] <= 1'b0;
        end
        if (wr_ok_s && (int'(i_wr_sel) == c)) begin
          pend_r[c]     <= i_wr_half;
          pend_vld_r[c] <= 1'b1;
        end
      end
    end
  end

  // Rejected-write flag, one cycle after the offending strobe.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_wr_err <= 1'b0;
    end else begin
      o_wr_err <= wr_bad_s;
    end
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// Self-checking bench: directed literal checks plus randomized traffic against a countdown model.
module tb_clock_div_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic [7:0] wr_half;
  logic       sync;
  logic [3:0] o_clk, o_tick;
  logic       o_err;

  logic [2:0] o_clk3, o_tick3;
  logic       o_err3;
  logic       wr3_en;
  logic [1:0] wr3_sel;
  logic [7:0] wr3_half;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clock_div_multi #(.NUM_CH(4), .CNT_W(8), .DEFAULT_HALF(5)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_wr_en(wr_en), .i_wr_sel(wr_sel),
    .i_wr_half(wr_half),
`ifdef CLKDIV_SYNC_EN
    .i_sync(sync),
`endif
    .o_clk(o_clk), .o_tick(o_tick), .o_wr_err(o_err)
  );

  clock_div_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_HALF(5)) u_dut3 (
    .i_clk(clk), .i_reset(rst), .i_en(3'b111), .i_wr_en(wr3_en), .i_wr_sel(wr3_sel),
    .i_wr_half(wr3_half),
`ifdef CLKDIV_SYNC_EN
    .i_sync(1'b0),
`endif
    .o_clk(o_clk3), .o_tick(o_tick3), .o_wr_err(o_err3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each channel counts down the edges left until its next toggle.
  int         m_half [4];
  int         m_pend [4];
  bit         m_pv   [4];
  int         m_rem  [4];
  logic [3:0] m_clk, m_tick;
  logic       m_err;

  always @(posedge clk) begin
    logic       r, we, sy;
    logic [3:0] e;
    logic [1:0] sel;
    logic [7:0] wh;
    r = rst; e = en; we = wr_en; sel = wr_sel; wh = wr_half;
`ifdef CLKDIV_SYNC_EN
    sy = sync;
`else
    sy = 1'b0;
`endif
    #1;
    if (r) begin
      for (int c = 0; c < 4; c++) begin
        m_half[c] = 5; m_pend[c] = 5; m_pv[c] = 1'b0; m_rem[c] = 5;
      end
      m_clk = 4'h0; m_tick = 4'h0; m_err = 1'b0;
    end else begin
      m_err = we && (wh == 8'd0);
      for (int c = 0; c < 4; c++) begin
        if (sy) begin
          if (m_pv[c]) begin m_half[c] = m_pend[c]; m_pv[c] = 1'b0; end
          m_rem[c] = m_half[c]; m_clk[c] = 1'b0; m_tick[c] = 1'b0;
        end else if (!e[c]) begin
          m_tick[c] = 1'b0;
          if (m_pv[c]) begin
            m_half[c] = m_pend[c]; m_pv[c] = 1'b0; m_rem[c] = m_half[c];
          end
        end else begin
          m_rem[c] = m_rem[c] - 1;
          if (m_rem[c] == 0) begin
            m_clk[c]  = ~m_clk[c];
            m_tick[c] = m_clk[c];
            if (m_pv[c]) begin m_half[c] = m_pend[c]; m_pv[c] = 1'b0; end
            m_rem[c] = m_half[c];
          end else begin
            m_tick[c] = 1'b0;
          end
        end
        if (we && (wh != 8'd0) && (int'(sel) == c)) begin
          m_pend[c] = int'(wh); m_pv[c] = 1'b1;
        end
      end
    end
    chk("model_o_clk", 32'(o_clk), 32'(m_clk));
    chk("model_o_tick", 32'(o_tick), 32'(m_tick));
    chk("model_o_wr_err", 32'(o_err), 32'(m_err));
  end

  initial begin
    rst = 1'b1; en = 4'hF; wr_en = 1'b0; wr_sel = 2'd0; wr_half = 8'd0; sync = 1'b0;
    wr3_en = 1'b0; wr3_sel = 2'd0; wr3_half = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset_o_clk", 32'(o_clk), 32'h0);
    rst = 1'b0;

    // Directed: edges counted from reset release
    for (int e = 1; e <= 21; e++) begin
      wr_en = (e == 7) || (e == 17) || (e == 21);
      wr_sel = (e == 7) ? 2'd1 : 2'd2;
      wr_half = (e == 7) ? 8'd2 : ((e == 21) ? 8'd3 : 8'd0);
      wr3_en = (e >= 17) && (e <= 19);
      wr3_sel = (e == 17) ? 2'd3 : 2'd2;
      wr3_half = (e == 18) ? 8'd0 : ((e == 17) ? 8'd4 : 8'd3);
      @(posedge clk); #1;
      case (e)
        4:  chk("e4_clk", 32'(o_clk), 32'h0);
        5:  begin chk("e5_clk", 32'(o_clk), 32'hF); chk("e5_tick", 32'(o_tick), 32'hF); end
        6:  chk("e6_tick", 32'(o_tick), 32'h0);
        10: chk("e10_clk", 32'(o_clk), 32'h0);
        11: chk("e11_clk1", 32'(o_clk[1]), 32'h0);
        12: begin chk("e12_clk1", 32'(o_clk[1]), 32'h1); chk("e12_tick1", 32'(o_tick[1]), 32'h1); end
        14: chk("e14_clk", 32'(o_clk), 32'h0);
        15: begin chk("e15_clk", 32'(o_clk), 32'hD); chk("e15_tick", 32'(o_tick), 32'hD); end
        16: chk("e16_tick", 32'(o_tick), 32'h2);
        17: begin chk("e17_err", 32'(o_err), 32'h1); chk("e17_err3", 32'(o_err3), 32'h1);
                  chk("e17_clk3", 32'(o_clk3), 32'h7); end
        18: begin chk("e18_err", 32'(o_err), 32'h0); chk("e18_err3", 32'(o_err3), 32'h1); end
        19: chk("e19_err3", 32'(o_err3), 32'h0);
        20: chk("e20_clk", 32'(o_clk), 32'h2);
        default: ;
      endcase
      @(negedge clk);
    end
    wr_en = 1'b0; wr3_en = 1'b0;

    // Asynchronous reset with a write pending on ch2
    #1 rst = 1'b1;
    #1;
    chk("async_rst_clk", 32'(o_clk), 32'h0);
    chk("async_rst_tick", 32'(o_tick), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
`ifdef CLKDIV_SYNC_EN
      sync = (e == 6);
`endif
      @(posedge clk); #1;
      case (e)
        3: chk("post_rst_e3_clk", 32'(o_clk), 32'h0);
        5: chk("post_rst_e5_clk", 32'(o_clk), 32'hF);
`ifdef CLKDIV_SYNC_EN
        6: chk("sync_clk", 32'(o_clk), 32'h0);
`else
        6: chk("post_rst_e6_clk", 32'(o_clk), 32'hF);
`endif
        default: ;
      endcase
      @(negedge clk);
    end
    sync = 1'b0;

    // Randomized traffic, checked every cycle by the model process
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 4; c++) en[c] = ($urandom_range(0, 9) != 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_sel  = 2'($urandom_range(0, 3));
      wr_half = 8'($urandom_range(0, 9));
      rst     = ($urandom_range(0, 299) == 0);
`ifdef CLKDIV_SYNC_EN
      sync    = ($urandom_range(0, 49) == 0);
`endif
      @(negedge clk);
    end
    rst = 1'b0; wr_en = 1'b0; sync = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
